sample_collector: RTL and testbench
===================================

# sample_collector

Scan scheduler and sample buffer for the pincontrol array. Periodically walks the enabled channels, pulses `output_sample`/`channel_select` onto the shared sampling bus, captures each controller's `sample_data` word, and pushes tagged entries into an internal FIFO. The FIFO is read by the MCU over the same EBI register bus used by the pin controllers. The block sits beside the pincontrol instances on the top-level sampling bus.

## Interface
- `POSITION`, 8'd240: EBI page; the block is selected when `addr[15:8] == POSITION`.
- `NUM_CHANNELS`, 16: channels scanned, indices 0..NUM_CHANNELS-1 (equal to each pincontrol POSITION); max 16.
- `FIFO_DEPTH`, 32: entries; power of two, minimum 4.
- `clk` in 1: system clock.
- `reset` in 1: synchronous, active-high.
- `enable` in 1: EBI chip enable.
- `addr` in 19: EBI address; `[7:0]` selects the register.
- `data_wr` in 1: EBI write strobe.
- `data_rd` in 1: EBI read strobe.
- `data_in` in 16: EBI write data.
- `data_out` out 16: registered read data; 0 when not selected.
- `output_sample` out 1: sample request to the pincontrol array.
- `channel_select` out 8: channel being sampled.
- `sample_data` in 32: shared sample bus; Z/X when no channel drives it.

## Operation
Registers (byte addresses, all reset to 0):
- CTRL (0): bit0 `run`; bit1 `flush` (write-1, self-clearing); bit2 `clr_ovf` (write-1, self-clearing).
- CHAN_MASK (1): bit k enables channel k.
- SCAN_DIV (2): cycles between scan triggers.
- FIFO_L (3): read returns `{8'b0, channel}` of the head entry.
- FIFO_H (4): read returns `{cnt[14:0], bit}` of the head entry and pops it. Reading when the FIFO is empty returns 0 and does not pop.
- STATUS (5): `{count[6:0], 6'b0, ovf, full, empty}`.

Reads of unmapped addresses return 0.

Scan trigger:
- A 16-bit divider counts down while `run`=1.
- At 0 it reloads from SCAN_DIV and raises a trigger.
- SCAN_DIV=0 triggers every cycle.
- A trigger that arrives while the FSM is not IDLE is dropped.

FSM states:
- IDLE: on trigger with CHAN_MASK≠0, `ch` ← lowest enabled index and go to REQ. On trigger with mask 0, stay in IDLE.
- REQ: `output_sample`=1, `channel_select`=`ch`; go to WAIT.
- WAIT: outputs low; the pincontrol registers its word this cycle; go to CAPT.
- CAPT: latch `sample_data` and validate it: marker `[15:4]==12'hABC` and `[3:1]==3'b111`, with no X/Z on the marker bits (X/Z fails the check).
  - Valid: push entry `{cnt=sample_data[30:16], bit=sample_data[0], channel=ch}`.
  - Invalid: no push.
  - Then `ch` ← next enabled index above `ch` and go to REQ, or go to IDLE if none remain.

Boundary rules:
- Push when full: entry dropped, sticky `ovf`=1.
- Push and pop in the same cycle when full: both take effect, count unchanged, no overflow.
- `flush` empties the FIFO in the write cycle's next edge. A push in that same cycle is discarded. Any scan in progress continues.
- `run` cleared mid-scan: FSM returns to IDLE on the next edge; `output_sample` is 0 from that edge; no further push.
- CHAN_MASK written mid-scan takes effect at the next-index search.
- `clr_ovf` and an overflow in the same cycle: `ovf` stays 1.
- `reset` mid-scan: IDLE, FIFO empty, all registers 0.

## Timing
- Reset values: `data_out`=0, `output_sample`=0, `channel_select`=0, `ovf`=0, `empty`=1.
- `output_sample` is registered and high for exactly one cycle per channel.
- A channel costs 3 cycles: REQ, WAIT, CAPT. A full 16-channel scan takes 48 cycles after the trigger edge.
- CAPT samples `sample_data` two edges after the edge that raised `output_sample`.
- A pushed entry is visible in STATUS and FIFO_L/H one cycle after CAPT.
- `data_out` is valid the cycle after a read strobe. A FIFO_H read pops on the strobe edge.
- Register writes take effect on the strobe edge.

## Configuration
- `SAMPLE_DEDUP_EN` defined: the block keeps a per-channel last-pushed `cnt` and a valid bit, both cleared on reset and `flush`. A valid sample whose `cnt` equals the stored value is not pushed and does not set `ovf`.
- `SAMPLE_DEDUP_EN` undefined: every valid sample is pushed; the table is absent.

## Test plan
- Mask=16'h0005, SCAN_DIV=100, run=1; channel 0 model drives cnt=3, bit=1; channel 2 drives cnt=7, bit=0 -> FIFO_L/H read 0x0000/0x0007 then 0x0002/0x000E; `output_sample` pulses at trigger+0 and trigger+3.
- Mask=16'h0002 with channel 1 undriven (Z) -> no push, STATUS=0x0001 after the scan.
- FIFO_DEPTH=4, SCAN_DIV=0, one channel, no reads -> count=4, full=1, ovf=1 after the 5th capture. Write CTRL=0x0005 -> ovf=0, full persists.
- Clear run during WAIT of channel 1 in a 3-channel scan -> no push for channel 1; FSM in IDLE; `output_sample` stays 0.
- Read FIFO_H on an empty FIFO -> returns 0, count stays 0; `flush` with 3 entries -> STATUS=0x0001 next cycle.
- `SAMPLE_DEDUP_EN`: channel 0 holds cnt=5 across two scans -> one entry; cnt→6 -> second entry.

Source files
------------

// File: rtl/sample_collector.sv
// Scan scheduler and tagged sample FIFO for the pincontrol sampling bus, read over the EBI.
// Optional build macro SAMPLE_DEDUP_EN: suppress pushes that repeat a channel's last cnt.
module sample_collector #(
   parameter logic [7:0] POSITION     = 8'd240,
   parameter int         NUM_CHANNELS = 16,
   parameter int         FIFO_DEPTH   = 32
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        enable,
   input  logic [18:0] addr,
   input  logic        data_wr,
   input  logic        data_rd,
   input  logic [15:0] data_in,
   output logic [15:0] data_out,
   output logic        output_sample,
   output logic [7:0]  channel_select,
   input  logic [31:0] sample_data
);

   localparam int AW = $clog2(FIFO_DEPTH);
   localparam int CW = AW + 1;

   typedef enum logic [1:0] {IDLE, REQ, WAIT, CAPT} state_t;

   state_t         state, state_n;
   logic [7:0]     ch, ch_n;
   logic           run;
   logic [15:0]    chan_mask, scan_div, div_cnt;
   logic           trigger;
   logic           sel, wr, rd, wr_ctrl, flush, clr_ovf;
   logic [7:0]     reg_a;
   logic           marker_ok, dup, push_try, push, pop, do_push, ovf_set;
   logic [23:0]    mem [FIFO_DEPTH];
   logic [AW-1:0]  wr_ptr, rd_ptr;
   logic [CW-1:0]  count;
   logic           empty, full, ovf;
   logic [23:0]    head;
   logic [15:0]    rdata;
   logic [4:0]     first_ch, next_ch;
   logic           unused;

   assign unused = ^{addr[18:16], sample_data[31]};

   // EBI decode; flush and clr_ovf exist only as write pulses
   assign sel     = enable && (addr[15:8] == POSITION);
   assign wr      = sel && data_wr;
   assign rd      = sel && data_rd;
   assign reg_a   = addr[7:0];
   assign wr_ctrl = wr && (reg_a == 8'd0);
   assign flush   = wr_ctrl && data_in[1];
   assign clr_ovf = wr_ctrl && data_in[2];

   always_ff @(posedge clk) begin
      if (reset) begin
         run       <= 1'b0;
         chan_mask <= '0;
         scan_div  <= '0;
      end else if (wr) begin
         case (reg_a)
            8'd0: run       <= data_in[0];
            8'd1: chan_mask <= data_in;
            8'd2: scan_div  <= data_in;
            default: ;
         endcase
      end
   end

   // Divider idles at 0 while stopped, so setting run triggers on the next cycle
   always_ff @(posedge clk) begin
      if (reset || !run)      div_cnt <= '0;
      else if (div_cnt == 0)  div_cnt <= scan_div;
      else                    div_cnt <= div_cnt - 16'd1;
   end
   assign trigger = run && (div_cnt == 0);

   // Lowest enabled channel index >= from; bit 4 flags a hit
   function automatic logic [4:0] find_from(input logic [15:0] m, input int from);
      logic [4:0] res;
      res = '0;
      for (int k = NUM_CHANNELS - 1; k >= 0; k--)
         if (k >= from && m[k]) res = {1'b1, 4'(k)};
      return res;
   endfunction

   assign first_ch = find_from(chan_mask, 0);
   assign next_ch  = find_from(chan_mask, int'(ch) + 1);

   assign marker_ok = !$isunknown(sample_data[15:1]) &&
                      (sample_data[15:4] == 12'hABC) && (sample_data[3:1] == 3'b111);

   always_comb begin
      state_n  = state;
      ch_n     = ch;
      push_try = 1'b0;
      case (state)
         IDLE: if (trigger && first_ch[4]) begin
            state_n = REQ;
            ch_n    = {4'b0, first_ch[3:0]};
         end
         REQ:  state_n = WAIT;
         WAIT: state_n = CAPT;
         CAPT: begin
            push_try = marker_ok;
            if (next_ch[4]) begin
               state_n = REQ;
               ch_n    = {4'b0, next_ch[3:0]};
            end else begin
               state_n = IDLE;
            end
         end
         default: state_n = IDLE;
      endcase
      if (!run) begin
         state_n  = IDLE;
         push_try = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state          <= IDLE;
         ch             <= '0;
         output_sample  <= 1'b0;
         channel_select <= '0;
      end else begin
         state          <= state_n;
         ch             <= ch_n;
         output_sample  <= (state_n == REQ);
         channel_select <= (state_n == REQ) ? ch_n : 8'd0;
      end
   end

`ifdef SAMPLE_DEDUP_EN
   logic [NUM_CHANNELS-1:0][14:0] last_cnt;
   logic [NUM_CHANNELS-1:0]       last_vld;

   always_comb begin
      dup = 1'b0;
      for (int k = 0; k < NUM_CHANNELS; k++)
         if (ch == 8'(k) && last_vld[k] && last_cnt[k] == sample_data[30:16]) dup = 1'b1;
   end

   // Table follows what actually landed in the FIFO
   always_ff @(posedge clk) begin
      if (reset || flush) begin
         last_vld <= '0;
         last_cnt <= '0;
      end else if (do_push) begin
         for (int k = 0; k < NUM_CHANNELS; k++)
            if (ch == 8'(k)) begin
               last_vld[k] <= 1'b1;
               last_cnt[k] <= sample_data[30:16];
            end
      end
   end
`else
   assign dup = 1'b0;
`endif

   assign push    = push_try && !dup;
   assign empty   = (count == 0);
   assign full    = (count == CW'(FIFO_DEPTH));
   assign pop     = rd && (reg_a == 8'd4) && !empty;
   // Full FIFO still accepts a push when a pop frees the slot in the same cycle
   assign do_push = push && (!full || pop) && !flush;
   assign ovf_set = push && full && !pop && !flush;
   assign head    = mem[rd_ptr];

   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr] <= {sample_data[30:16], sample_data[0], ch};
   end

   always_ff @(posedge clk) begin
      if (reset || flush) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + AW'(1);
         if (pop)     rd_ptr <= rd_ptr + AW'(1);
         case ({do_push, pop})
            2'b10:   count <= count + CW'(1);
            2'b01:   count <= count - CW'(1);
            default: ;
         endcase
      end
   end

   // Overflow wins over a simultaneous clear
   always_ff @(posedge clk) begin
      if (reset)        ovf <= 1'b0;
      else if (ovf_set) ovf <= 1'b1;
      else if (clr_ovf) ovf <= 1'b0;
   end

   always_comb begin
      rdata = '0;
      case (reg_a)
         8'd0: rdata = {15'b0, run};
         8'd1: rdata = chan_mask;
         8'd2: rdata = scan_div;
         8'd3: rdata = empty ? 16'd0 : {8'b0, head[7:0]};
         8'd4: rdata = empty ? 16'd0 : head[23:8];
         8'd5: rdata = {7'(count), 6'b0, ovf, full, empty};
         default: rdata = '0;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) data_out <= '0;
      else       data_out <= rd ? rdata : 16'd0;
   end

endmodule

// File: tb/tb_sample_collector.sv
// Directed bench for sample_collector: scan timing, tagging, FIFO boundaries, run/flush/reset.
module tb_sample_collector;

   localparam logic [7:0] POS = 8'd240;

   logic        clk = 1'b0;
   logic        reset;
   logic        enable;
   logic [18:0] addr;
   logic        data_wr;
   logic        data_rd;
   logic [15:0] data_in;
   logic [15:0] data_out;
   logic        output_sample;
   logic [7:0]  channel_select;
   wire  [31:0] sample_data;

   int total = 0;
   int bad   = 0;

   logic [3:0]  sel_ch = '0;
   logic [14:0] mdl_cnt [16];
   logic        mdl_bit [16];
   logic        mdl_drv [16];

   sample_collector #(.POSITION(POS), .NUM_CHANNELS(16), .FIFO_DEPTH(4)) dut (
      .clk(clk), .reset(reset), .enable(enable), .addr(addr),
      .data_wr(data_wr), .data_rd(data_rd), .data_in(data_in), .data_out(data_out),
      .output_sample(output_sample), .channel_select(channel_select),
      .sample_data(sample_data)
   );

   always #5 clk = ~clk;

   // Pin controller model: latch the request, hold the word until the next request
   always @(posedge clk) if (output_sample) sel_ch <= channel_select[3:0];
   assign sample_data = mdl_drv[sel_ch] ?
                        {1'b0, mdl_cnt[sel_ch], 12'hABC, 3'b111, mdl_bit[sel_ch]} : 32'bz;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic wr_reg(input logic [7:0] a, input logic [15:0] d);
      enable = 1'b1; addr = {3'b0, POS, a}; data_in = d; data_wr = 1'b1;
      @(posedge clk); #1;
      data_wr = 1'b0; enable = 1'b0;
   endtask

   task automatic rd_reg(input logic [7:0] a, output logic [15:0] d);
      enable = 1'b1; addr = {3'b0, POS, a}; data_rd = 1'b1;
      @(posedge clk); #1;
      data_rd = 1'b0; enable = 1'b0;
      d = data_out;
   endtask

   task automatic idle(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   // Returns at the negedge inside the REQ cycle of channel chn
   task automatic wait_pulse(input logic [7:0] chn, output logic ok);
      ok = 1'b0;
      for (int i = 0; i < 200 && !ok; i++) begin
         @(negedge clk);
         if (output_sample && channel_select == chn) ok = 1'b1;
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [15:0] d;
      logic        ok;
      int          np, p0, p1, c0, c1, seen;

      for (int k = 0; k < 16; k++) begin
         mdl_cnt[k] = 15'(k); mdl_bit[k] = 1'b0; mdl_drv[k] = 1'b0;
      end
      mdl_cnt[0] = 15'd3; mdl_bit[0] = 1'b1; mdl_drv[0] = 1'b1;
      mdl_cnt[1] = 15'd9; mdl_bit[1] = 1'b1;
      mdl_cnt[2] = 15'd7; mdl_bit[2] = 1'b0; mdl_drv[2] = 1'b1;

      reset = 1'b1; enable = 1'b0; addr = '0; data_wr = 1'b0; data_rd = 1'b0; data_in = '0;
      idle(3);
      reset = 1'b0;
      chk("rst_data_out", 32'(data_out), 32'h0);
      chk("rst_output_sample", 32'(output_sample), 32'h0);
      chk("rst_channel_select", 32'(channel_select), 32'h0);
      rd_reg(8'd5, d); chk("rst_status", 32'(d), 32'h0001);
      rd_reg(8'd0, d); chk("rst_ctrl", 32'(d), 32'h0000);

      // Two-channel scan: pulse spacing and tagged entries
      wr_reg(8'd1, 16'h0005);
      wr_reg(8'd2, 16'd100);
      wr_reg(8'd0, 16'h0001);
      np = 0; p0 = -1; p1 = -1; c0 = -1; c1 = -1;
      for (int i = 0; i < 20; i++) begin
         @(posedge clk); #1;
         if (output_sample) begin
            if (np == 0) begin p0 = i; c0 = int'(channel_select); end
            else if (np == 1) begin p1 = i; c1 = int'(channel_select); end
            np++;
         end
      end
      chk("scan_pulse_count", 32'(np), 32'd2);
      chk("scan_pulse_gap", 32'(p1 - p0), 32'd3);
      chk("scan_first_chan", 32'(c0), 32'd0);
      chk("scan_second_chan", 32'(c1), 32'd2);
      wr_reg(8'd0, 16'h0000);
      rd_reg(8'd5, d); chk("scan_status_two", 32'(d), 32'h0400);
      rd_reg(8'd3, d); chk("fifo_l_ch0", 32'(d), 32'h0000);
      rd_reg(8'd4, d); chk("fifo_h_ch0", 32'(d), 32'h0007);
      rd_reg(8'd3, d); chk("fifo_l_ch2", 32'(d), 32'h0002);
      rd_reg(8'd4, d); chk("fifo_h_ch2", 32'(d), 32'h000E);
      rd_reg(8'd5, d); chk("scan_status_drained", 32'(d), 32'h0001);

      // Undriven channel: bus floats, marker check rejects it
      wr_reg(8'd1, 16'h0002);
      wr_reg(8'd0, 16'h0001);
      wait_pulse(8'd1, ok); chk("undriven_pulse_seen", 32'(ok), 32'h1);
      #1; idle(6);
      wr_reg(8'd0, 16'h0000);
      rd_reg(8'd5, d); chk("undriven_status", 32'(d), 32'h0001);

      // Clear run during WAIT of channel 1 in a three-channel scan
      mdl_drv[1] = 1'b1;
      wr_reg(8'd0, 16'h0002);
      wr_reg(8'd1, 16'h0007);
      wr_reg(8'd0, 16'h0001);
      wait_pulse(8'd1, ok); chk("stop_pulse_ch1", 32'(ok), 32'h1);
      @(posedge clk); #1;
      wr_reg(8'd0, 16'h0000);
      seen = 0;
      for (int i = 0; i < 10; i++) begin
         @(posedge clk); #1;
         if (output_sample) seen++;
      end
      chk("stop_no_pulse", 32'(seen), 32'd0);
      rd_reg(8'd5, d); chk("stop_status_one", 32'(d), 32'h0200);
      rd_reg(8'd4, d); chk("stop_head_ch0", 32'(d), 32'h0007);

      // Empty pop, then flush with three entries
      rd_reg(8'd4, d); chk("empty_pop_data", 32'(d), 32'h0000);
      rd_reg(8'd5, d); chk("empty_pop_status", 32'(d), 32'h0001);
      wr_reg(8'd0, 16'h0002);
      wr_reg(8'd0, 16'h0001);
      idle(15);
      wr_reg(8'd0, 16'h0000);
      rd_reg(8'd5, d); chk("flush_pre_status", 32'(d), 32'h0600);
      wr_reg(8'd0, 16'h0002);
      rd_reg(8'd5, d); chk("flush_post_status", 32'(d), 32'h0001);

      // Same cnt on channel 0 across two scans, then a new cnt
      mdl_cnt[0] = 15'd5;
      wr_reg(8'd1, 16'h0001);
      wr_reg(8'd2, 16'd20);
      wr_reg(8'd0, 16'h0001);
      idle(30);
      wr_reg(8'd0, 16'h0000);
      rd_reg(8'd5, d);
`ifdef SAMPLE_DEDUP_EN
      chk("dedup_same_cnt", 32'(d), 32'h0200);
`else
      chk("dedup_same_cnt", 32'(d), 32'h0400);
`endif
      mdl_cnt[0] = 15'd6;
      wr_reg(8'd0, 16'h0001);
      idle(10);
      wr_reg(8'd0, 16'h0000);
      rd_reg(8'd5, d);
`ifdef SAMPLE_DEDUP_EN
      chk("dedup_new_cnt", 32'(d), 32'h0400);
`else
      chk("dedup_new_cnt", 32'(d), 32'h0600);
`endif
      wr_reg(8'd0, 16'h0002);

      // Overflow with SCAN_DIV=0 and a single channel
      mdl_cnt[0] = 15'd3;
      wr_reg(8'd2, 16'd0);
      wr_reg(8'd0, 16'h0001);
      idle(40);
      rd_reg(8'd5, d); chk("ovf_status_full", 32'(d), 32'h0806);
      wait_pulse(8'd0, ok); chk("ovf_sync_pulse", 32'(ok), 32'h1);
      wr_reg(8'd0, 16'h0005);
      rd_reg(8'd5, d); chk("ovf_cleared_full", 32'(d), 32'h0802);
      // This pop lands on the CAPT edge: push and pop together, no overflow
      rd_reg(8'd4, d); chk("ovf_pushpop_data", 32'(d), 32'h0007);
      rd_reg(8'd5, d); chk("ovf_pushpop_status", 32'(d), 32'h0802);

      // Reset in the middle of a scan
      wait_pulse(8'd0, ok); chk("rst_mid_pulse", 32'(ok), 32'h1);
      reset = 1'b1;
      @(posedge clk); #1;
      reset = 1'b0;
      chk("rst_mid_output_sample", 32'(output_sample), 32'h0);
      rd_reg(8'd5, d); chk("rst_mid_status", 32'(d), 32'h0001);
      rd_reg(8'd0, d); chk("rst_mid_ctrl", 32'(d), 32'h0000);
      rd_reg(8'd1, d); chk("rst_mid_mask", 32'(d), 32'h0000);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
